// File: rtl/pixel_pkg.sv
// Shared constants, state encoding and plot-entry layout for the pixel writer.
package pixel_pkg;

  localparam logic [7:0]  SCREEN_W    = 8'd160;
  localparam logic [6:0]  SCREEN_H    = 7'd120;
  localparam int unsigned FB_ADDR_W   = 15;
  localparam int unsigned COLOR_DEPTH = 9;

  localparam logic [FB_ADDR_W-1:0] FB_LAST_ADDR = 15'd19199;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } pw_state_t;

  typedef struct packed {
    logic [7:0]             x;
    logic [6:0]             y;
    logic [COLOR_DEPTH-1:0] color;
  } plot_entry_t;

  localparam int unsigned PLOT_ENTRY_W = $bits(plot_entry_t);

  // y*160 as (y<<7)+(y<<5), keeping the datapath to adders only.
  function automatic logic [FB_ADDR_W-1:0] fb_linear_addr(input logic [7:0] x,
                                                          input logic [6:0] y);
    logic [FB_ADDR_W-1:0] w_y;
    w_y = {8'b0, y};
    return (w_y << 7) + (w_y << 5) + {7'b0, x};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_writer.sv
// Plot-request buffer and framebuffer writer with full-screen clear sequence.
// Optional PIXEL_WRITER_TRANSPARENT_EN drops pushes whose colour equals TRANSPARENT_COLOR.
module pixel_writer
  import pixel_pkg::*;
#(
  parameter int unsigned            FIFO_DEPTH  = 16,
  parameter logic [COLOR_DEPTH-1:0] CLEAR_COLOR = '0
`ifdef PIXEL_WRITER_TRANSPARENT_EN
  ,
  parameter logic [COLOR_DEPTH-1:0] TRANSPARENT_COLOR = 9'h1FF
`endif
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [7:0]             x,
  input  logic [6:0]             y,
  input  logic [COLOR_DEPTH-1:0] color,
  input  logic                   plot,
  output logic                   ready,
  input  logic                   clear_req,
  output logic                   clear_done,
  output logic                   overflow,
  input  logic                   fb_grant,
  output logic [FB_ADDR_W-1:0]   fb_address,
  output logic [COLOR_DEPTH-1:0] fb_data,
  output logic                   fb_wren
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  pw_state_t              r_state, w_next_state;
  logic [FB_ADDR_W-1:0]   r_clr_cnt;
  logic [FB_ADDR_W-1:0]   r_fb_address;
  logic [COLOR_DEPTH-1:0] r_fb_data;
  logic                   r_fb_wren;
  logic                   r_overflow;

  plot_entry_t            w_in_entry, w_out_entry;
  logic                   w_full, w_empty;
  logic [CW-1:0]          w_count;
  logic                   w_in_range, w_keep, w_busy;
  logic                   w_push, w_drop, w_pop, w_clr_wr, w_fifo_drained;

  assign w_in_entry = '{x: x, y: y, color: color};
  assign w_in_range = (x < SCREEN_W) && (y < SCREEN_H);
`ifdef PIXEL_WRITER_TRANSPARENT_EN
  assign w_keep     = (color != TRANSPARENT_COLOR);
`else
  assign w_keep     = 1'b1;
`endif
  assign w_busy     = (r_state == CLEAR) || (r_state == DONE);
  assign ready      = !w_full && !w_busy;
  assign w_push     = plot && ready && w_in_range && w_keep;
  assign w_drop     = plot && !ready && w_in_range && w_keep;
  assign w_pop      = ((r_state == IDLE) || (r_state == DRAIN)) && !w_empty && fb_grant;
  assign w_clr_wr   = (r_state == CLEAR) && fb_grant;
  // FIFO will be empty after this edge: nothing arriving and nothing (or only the last entry) left.
  assign w_fifo_drained = !w_push && (w_empty || ((w_count == CW'(1)) && w_pop));

  sync_fifo #(
    .WIDTH (PLOT_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (resetn),
    .i_push  (w_push),
    .i_wdata (w_in_entry),
    .i_pop   (w_pop),
    .o_rdata (w_out_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (clear_req) w_next_state = w_fifo_drained ? CLEAR : DRAIN;
      DRAIN:   if (w_fifo_drained) w_next_state = CLEAR;
      CLEAR:   if (w_clr_wr && (r_clr_cnt == FB_LAST_ADDR)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_clr_cnt    <= '0;
      r_fb_address <= '0;
      r_fb_data    <= '0;
      r_fb_wren    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_fb_wren <= w_pop || w_clr_wr;
      if (w_pop) begin
        r_fb_address <= fb_linear_addr(w_out_entry.x, w_out_entry.y);
        r_fb_data    <= w_out_entry.color;
      end else if (w_clr_wr) begin
        r_fb_address <= r_clr_cnt;
        r_fb_data    <= CLEAR_COLOR;
      end
      if (w_clr_wr) r_clr_cnt <= (r_clr_cnt == FB_LAST_ADDR) ? '0 : r_clr_cnt + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      else if ((r_state == IDLE) && clear_req) r_overflow <= 1'b0;
    end
  end

  assign fb_address = r_fb_address;
  assign fb_data    = r_fb_data;
  assign fb_wren    = r_fb_wren;
  assign overflow   = r_overflow;
  assign clear_done = (r_state == DONE);

endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Receiving end of the plot interface driven by the background/tile drawing engines (x, y, color, plot).
- Buffers plot requests in a FIFO, translates (x, y) into a linear framebuffer address, and writes the pixel into framebuffer RAM whenever the arbiter grants a write slot.
- Also provides a full-screen clear sequence.
- Sits between the drawing engines and the VGA framebuffer memory.

Parameters:
- SCREEN_W, 160, pixels per row
- SCREEN_H, 120, rows
- FIFO_DEPTH, 16, plot-request FIFO entries (power of two)
- COLOR_DEPTH, 9, bits per pixel
- CLEAR_COLOR, 9'd0, colour written by the clear sequence

Ports:
- clock  in  1  system clock
- resetn  in  1  reset; clock is the single clock, reset is asynchronous and active-low
- x  in  8  pixel column
- y  in  7  pixel row
- color  in  COLOR_DEPTH  pixel colour
- plot  in  1  one-cycle plot request per pixel
- ready  out  1  FIFO not full and state not CLEAR/DONE
- clear_req  in  1  pulse requesting a full-screen clear
- clear_done  out  1  one-cycle pulse when the clear finishes
- overflow  out  1  sticky: a request was dropped while ready=0
- fb_grant  in  1  framebuffer write slot available this cycle
- fb_address  out  15  linear address, y*SCREEN_W + x
- fb_data  out  COLOR_DEPTH  write data
- fb_wren  out  1  write strobe

Behaviour:
- Reset values: fb_wren=0, fb_address=0, fb_data=0, clear_done=0, overflow=0. FIFO is empty, state is IDLE, ready=1.
- Push: on plot && ready && x<SCREEN_W && y<SCREEN_H, the FIFO stores {x, y, color}.
  - Out-of-range coordinates are silently discarded and do not set overflow.
  - plot && !ready is discarded and sets overflow.
- Full check uses the count at the start of the cycle: a push while full is dropped even if a pop happens in the same cycle.
- Pop: when state is IDLE or DRAIN, the FIFO is non-empty, and fb_grant=1.
  - The popped entry is registered as fb_address=y*SCREEN_W+x, fb_data=color, fb_wren=1 on the next cycle.
  - Latency from plot (cycle N) to fb_wren is 2 cycles (N+2) when fb_grant is held high.
  - fb_wren=0 in any cycle with no pop or clear write.
- Sustained throughput is 1 pixel/clock with fb_grant=1. Simultaneous push and pop leave the count unchanged.
- Address arithmetic: y*160 is computed as (y<<7)+(y<<5); the 15-bit result has a maximum of 19199.
- State machine:
  - IDLE: on clear_req, go to DRAIN if the FIFO is non-empty, else to CLEAR. Also clears overflow.
  - DRAIN: pops continue, pushes are still accepted. When the FIFO is empty → CLEAR.
  - CLEAR: ready=0. A 15-bit clear counter starts at 0.
    - Each cycle with fb_grant=1, emit one write (address=counter, data=CLEAR_COLOR) and increment.
    - After writing 19199 → DONE.
    - fb_grant=0 stalls the counter without skipping addresses.
  - DONE: clear_done=1 for exactly one cycle → IDLE.
- clear_req outside IDLE is ignored.
- Reset mid-operation (any state, including mid-clear or a non-empty FIFO) returns everything to reset values immediately; FIFO contents are lost.

Optional Feature:
- Macro: PIXEL_WRITER_TRANSPARENT_EN.
- Defined:
  - Adds parameter TRANSPARENT_COLOR (default 9'h1FF).
  - Push requests with color==TRANSPARENT_COLOR are discarded at input: no FIFO entry, no overflow, ready unaffected.
  - Clear writes are unaffected.
- Undefined: every in-range colour is written.

Decomposition:
- Shared package pixel_pkg holds:
  - SCREEN_W, SCREEN_H, FB_ADDR_W=15, COLOR_DEPTH
  - the state encoding localparams (IDLE=0, DRAIN=1, CLEAR=2, DONE=3)
  - the plot-entry struct/width constant {x[7:0], y[6:0], color}.
- One sub-module, sync_fifo: parameterised width/depth, with push, pop, full, empty and count. It has no knowledge of pixels.

Test Plan:
- Single plot x=5, y=3, color=9'h0AB with fb_grant=1 → fb_wren at N+2 with fb_address=485, fb_data=9'h0AB.
- 20 back-to-back plots with fb_grant=0, then grant raised → first 16 are written in order, the last 4 are dropped, overflow=1, ready=0 while full.
- Plot x=160, y=0 and x=0, y=120 → no write, overflow stays 0.
- clear_req with 3 entries queued and fb_grant toggling 50% → the 3 pixels are written first, then addresses 0..19199 each exactly once with data 0, clear_done pulses once, and overflow is cleared.
- resetn asserted during CLEAR at counter 5000 → outputs return to reset values at once. After release: ready=1, no further writes, clear_done never pulses.
- With PIXEL_WRITER_TRANSPARENT_EN: plot color=9'h1FF → no write. Plot color=9'h1FE → written.
